// File: rtl/read_cycle_pkg.sv
// read_cycle_pkg: states, output decode and constants shared by the SRAM read controller.
package read_cycle_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, LATCH, RECOVER} state_t;
    typedef struct packed {
        logic latch;
        logic count;
        logic not_ce;
        logic not_oe;
        logic reading;
    } outs_t;
    localparam int ACCESS_CYCLES_DEF = 2;
    localparam int CTR_W = 4;
    localparam outs_t OUT_IDLE    = 5'b00110;
    localparam outs_t OUT_SETUP   = 5'b00011;
    localparam outs_t OUT_ACCESS  = 5'b00001;
    localparam outs_t OUT_LATCH   = 5'b10001;
    localparam outs_t OUT_RECOVER = 5'b01111;
    function automatic outs_t state_outs(input state_t s);
        case (s)
            SETUP:   return OUT_SETUP;
            ACCESS:  return OUT_ACCESS;
            LATCH:   return OUT_LATCH;
            RECOVER: return OUT_RECOVER;
            default: return OUT_IDLE;
        endcase
    endfunction
endpackage

// File: rtl/read_cycle_wait_ctr.sv
// read_cycle_wait_ctr: loadable down-counter timing the ACCESS phase, with zero flag.
module read_cycle_wait_ctr
    import read_cycle_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CTR_W-1:0] load_val,
    output logic             zero
);
    logic [CTR_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CTR_W'(1);
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/read_cycle.sv
// read_cycle: Moore FSM sequencing one async SRAM read per accepted request.
// Define READ_CYCLE_EDGE_TRIG_EN to accept only on a rising edge of read.
module read_cycle
    import read_cycle_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic read,
    input  logic write,
    output logic latch,
    output logic count,
    output logic not_ce,
    output logic not_oe,
    output logic reading
);
    state_t state, next;
    logic   accept, zero;
`ifdef READ_CYCLE_EDGE_TRIG_EN
    logic read_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            read_q <= 1'b0;
        else
            read_q <= read;
    end
    assign accept = read && !read_q && !write;
`else
    assign accept = read && !write;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next;
    end
    // if (rather than a ternary) keeps an unknown request from leaving IDLE
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = SETUP;
            SETUP:   next = ACCESS;
            ACCESS:  if (zero) next = LATCH;
            LATCH:   next = RECOVER;
            default: next = IDLE;
        endcase
    end
    read_cycle_wait_ctr u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (state == SETUP),
        .dec      (state == ACCESS),
        .load_val (CTR_W'(ACCESS_CYCLES - 1)),
        .zero     (zero)
    );
    assign {latch, count, not_ce, not_oe, reading} = state_outs(state);
endmodule

// File: tb/tb_read_cycle.sv
// tb_read_cycle: directed checks of read_cycle with ACCESS_CYCLES = 1, 2 and 5 side by side.
module tb_read_cycle;
    localparam logic [4:0] I = 5'b00110;
    localparam logic [4:0] S = 5'b00011;
    localparam logic [4:0] A = 5'b00001;
    localparam logic [4:0] L = 5'b10001;
    localparam logic [4:0] R = 5'b01111;
    logic clk = 1'b0;
    logic reset, read, write;
    logic latch1, count1, nce1, noe1, rd1;
    logic latch2, count2, nce2, noe2, rd2;
    logic latch5, count5, nce5, noe5, rd5;
    logic [4:0] o1, o2, o5;
    int errors = 0;
    int checks = 0;
    logic [4:0] e1[9] = '{S, A, L, R, I, I, I, I, I};
    logic [4:0] e2[9] = '{S, A, A, L, R, I, I, I, I};
    logic [4:0] e5[9] = '{S, A, A, A, A, A, L, R, I};
`ifdef READ_CYCLE_EDGE_TRIG_EN
    logic [4:0] eh[13] = '{S, A, A, L, R, I, I, I, I, I, I, I, I};
`else
    logic [4:0] eh[13] = '{S, A, A, L, R, I, S, A, A, L, R, I, I};
`endif
    assign o1 = {latch1, count1, nce1, noe1, rd1};
    assign o2 = {latch2, count2, nce2, noe2, rd2};
    assign o5 = {latch5, count5, nce5, noe5, rd5};
    always #5 clk = ~clk;
    read_cycle #(.ACCESS_CYCLES(1)) u1 (.clk(clk), .reset(reset), .read(read), .write(write),
        .latch(latch1), .count(count1), .not_ce(nce1), .not_oe(noe1), .reading(rd1));
    read_cycle #(.ACCESS_CYCLES(2)) u2 (.clk(clk), .reset(reset), .read(read), .write(write),
        .latch(latch2), .count(count2), .not_ce(nce2), .not_oe(noe2), .reading(rd2));
    read_cycle #(.ACCESS_CYCLES(5)) u5 (.clk(clk), .reset(reset), .read(read), .write(write),
        .latch(latch5), .count(count5), .not_ce(nce5), .not_oe(noe5), .reading(rd5));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b (latch/count/not_ce/not_oe/reading)", tag, got, exp);
        end
    endtask
    task automatic chk_all_idle(input string tag);
        chk({tag, "_ac1"}, o1, I);
        chk({tag, "_ac2"}, o2, I);
        chk({tag, "_ac5"}, o5, I);
    endtask
    // read must already be high for the first edge; it is dropped right after it
    task automatic run_seq(input string tag);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) read = 1'b0;
            chk($sformatf("%s_ac1_e%0d", tag, i + 1), o1, e1[i]);
            chk($sformatf("%s_ac2_e%0d", tag, i + 1), o2, e2[i]);
            chk($sformatf("%s_ac5_e%0d", tag, i + 1), o5, e5[i]);
        end
    endtask
    initial begin
        reset = 1'b0;
        read  = 1'bx;
        write = 1'bx;
        #1;
        chk_all_idle("reset_init");
        tick();
        tick();
        chk_all_idle("reset_held_x");
        read  = 1'b0;
        write = 1'b0;
        #4;
        reset = 1'b1;
        tick();
        tick();
        chk_all_idle("post_reset_idle");
        read = 1'b1;
        run_seq("single");
        read  = 1'b1;
        write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_idle($sformatf("conflict_%0d", i));
        end
`ifdef READ_CYCLE_EDGE_TRIG_EN
        read = 1'b0;
        tick();
        read = 1'b1;
`endif
        write = 1'b0;
        run_seq("after_conflict");
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        chk("midop_pre_ac2", o2, A);
        chk("midop_pre_ac5", o5, A);
        #2;
        reset = 1'b0;
        #1;
        chk_all_idle("midop_async");
        tick();
        chk_all_idle("midop_held1");
        tick();
        chk_all_idle("midop_held2");
        #4;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_idle($sformatf("midop_release_%0d", i));
        end
        read = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 11) read = 1'b0;
            chk($sformatf("held_ac2_e%0d", i + 1), o2, eh[i]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/read_cycle.md
Name: read_cycle

Overview:
Moore-style controller that sequences one asynchronous SRAM read cycle per accepted request.
- Drives chip-enable and output-enable (both active-low), a data-latch strobe and an address-counter advance pulse.
- Sits between the host request logic (read/write strobes) and the external memory datapath (address counter, data latch).
- Write cycles are owned by another block; here `write` only blocks read acceptance.

Parameters:
ACCESS_CYCLES, 2, number of cycles not_oe is held low before the data latch strobe; legal range 1..15.

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset; forces IDLE immediately
read  input  1  read request, sampled on rising clk
write  input  1  write request; when high, a read is not accepted
latch  output  1  one-cycle strobe: capture memory data into the external latch
count  output  1  one-cycle pulse: advance external address counter
not_ce  output  1  memory chip enable, active-low
not_oe  output  1  memory output enable, active-low
reading  output  1  high while a read cycle is in progress (busy)

Behaviour:
- All outputs are decoded from registered state only; no combinational path from inputs to outputs.
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0. Outputs: latch=0, count=0, not_ce=1, not_oe=1, reading=0. Reset mid-cycle aborts the cycle immediately, with no latch or count pulse.
- States and outputs, listed as latch/count/not_ce/not_oe/reading:
  - IDLE 0/0/1/1/0
  - SETUP 0/0/0/1/1
  - ACCESS 0/0/0/0/1
  - LATCH 1/0/0/0/1
  - RECOVER 0/1/1/1/1
- Transitions:
  - IDLE -> SETUP when read=1 and write=0 at a rising edge; otherwise stay in IDLE.
  - SETUP -> ACCESS after 1 cycle; load wait counter with ACCESS_CYCLES-1.
  - ACCESS: stay while counter != 0, decrementing each cycle; go to LATCH when counter == 0. ACCESS therefore lasts exactly ACCESS_CYCLES cycles.
  - LATCH -> RECOVER after 1 cycle.
  - RECOVER -> IDLE after 1 cycle.
- Latency: request accepted at edge E0. With ACCESS_CYCLES=2:
  - E1: not_ce=0, reading=1
  - E2: not_oe=0
  - E4: latch=1 for one cycle
  - E5: count=1 for one cycle, not_ce=not_oe=1
  - E6: reading=0
  - Busy length is ACCESS_CYCLES+3 cycles.
- Once a cycle is accepted, read/write inputs are ignored until IDLE is re-entered. Dropping read or raising write mid-cycle does not shorten or abort it.
- read=1 and write=1 together in IDLE: no cycle starts; outputs stay at IDLE values.
- Level-sensitive request: read held high restarts a new cycle from IDLE on the next edge, giving exactly one IDLE cycle between back-to-back reads.
- Unknown (X) read/write before reset completes must not leave IDLE once reset deasserts with read=0.
- latch and count are never high in the same cycle. not_oe=0 only while not_ce=0.

Optional Feature:
READ_CYCLE_EDGE_TRIG_EN
- Defined: a cycle starts only on a rising edge of read. read is registered internally; acceptance requires current read=1, previous read=0, and write=0. Holding read high yields exactly one cycle; read must return low for at least one clock before the next request.
- Undefined: level-sensitive acceptance as in Behaviour.
- The edge-detect register resets to 0.

Decomposition:
- Package read_cycle_pkg:
  - state enum typedef (IDLE, SETUP, ACCESS, LATCH, RECOVER), 3-bit encoding
  - per-state output constant
  - default ACCESS_CYCLES constant
  - wait-counter width constant (4 bits)
- One sub-module, read_cycle_wait_ctr: loadable 4-bit down-counter with load, decrement and zero flag, async active-low reset. The FSM and output decode stay in read_cycle.

Test Plan:
- Reset: assert reset=0 mid-simulation -> outputs 0/0/1/1/0 immediately without a clock edge; hold through reset=1.
- Single read, ACCESS_CYCLES=2, 10-unit clock period: read=1 for one period -> not_ce low edges 1-4, not_oe low edges 2-4, latch high edge 4 only, count high edge 5 only, reading high edges 1-5, idle at edge 6.
- Conflict: read=1 and write=1 for 3 cycles -> no output change. Then write=0 -> cycle starts on next edge.
- Reset mid-operation: reset=0 during ACCESS -> immediate IDLE outputs; no latch/count pulse. After release with read=0, stays in IDLE.
- Held read (macro undefined): read=1 for 12 cycles -> two complete cycles, one IDLE cycle between. With READ_CYCLE_EDGE_TRIG_EN defined -> exactly one cycle.
- ACCESS_CYCLES=1 and ACCESS_CYCLES=5: latch lands on edge 3 and edge 7 respectively; count one cycle later in each case.
